// File: rtl/ex_mem_pipe_reg_if.sv
// ex_mem_pipe_reg_if: valid/ready bus between the EX stage, the EX/MEM register and the MEM stage.
interface ex_mem_pipe_reg_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CTRL_W = 4
);
  logic              in_valid;
  logic              in_ready;
  logic [CTRL_W-1:0] in_ctrl;
  logic [DATA_W-1:0] in_alu_result;
  logic [DATA_W-1:0] in_write_data;
  logic [ADDR_W-1:0] in_write_reg;
  logic              out_valid;
  logic              out_ready;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DATA_W-1:0] out_alu_result;
  logic [DATA_W-1:0] out_write_data;
  logic [ADDR_W-1:0] out_write_reg;
  modport master (
    output in_valid, in_ctrl, in_alu_result, in_write_data, in_write_reg, out_ready,
    input  in_ready, out_valid, out_ctrl, out_alu_result, out_write_data, out_write_reg
  );
  modport slave (
    input  in_valid, in_ctrl, in_alu_result, in_write_data, in_write_reg, out_ready,
    output in_ready, out_valid, out_ctrl, out_alu_result, out_write_data, out_write_reg
  );
endinterface

// File: rtl/ex_mem_pipe_reg.sv
// ex_mem_pipe_reg: EX/MEM pipeline register as a two-entry skid buffer with flush, forwarding tap and stall counter.
module ex_mem_pipe_reg #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CTRL_W = 4,
  parameter int RW_BIT = 2,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  ex_mem_pipe_reg_if.slave bus,
  output logic             fwd_valid,
  output logic [CNT_W-1:0] stall_cnt
);
  typedef enum logic [1:0] {EMPTY, FULL, SKID} state_t;
  state_t state, state_n;
  logic [CTRL_W-1:0] m_ctrl, s_ctrl;
  logic [DATA_W-1:0] m_alu, s_alu, m_wd, s_wd;
  logic [ADDR_W-1:0] m_wr, s_wr;
  logic take_in, main_from_in, skid_from_in, main_from_skid;
  assign bus.out_valid      = state != EMPTY;
  assign bus.in_ready       = state != SKID;
  assign bus.out_ctrl       = bus.out_valid ? m_ctrl : '0;
  assign bus.out_alu_result = m_alu;
  assign bus.out_write_data = m_wd;
  assign bus.out_write_reg  = m_wr;
  assign fwd_valid = bus.out_valid & bus.out_ctrl[RW_BIT] & (|bus.out_write_reg);
  assign take_in        = bus.in_valid & bus.in_ready & !flush;
  assign main_from_in   = take_in & (state == EMPTY | bus.out_ready);
  assign skid_from_in   = take_in & state == FULL & !bus.out_ready;
  assign main_from_skid = !flush & state == SKID & bus.out_ready;
  always_comb begin
    state_n = flush           ? EMPTY :
              state == EMPTY  ? (bus.in_valid ? FULL : EMPTY) :
              state == FULL   ? (bus.out_ready ? (bus.in_valid ? FULL : EMPTY)
                                               : (bus.in_valid ? SKID : FULL)) :
                                (bus.out_ready ? FULL : SKID);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= EMPTY;
      m_ctrl    <= '0;
      m_alu     <= '0;
      m_wd      <= '0;
      m_wr      <= '0;
      s_ctrl    <= '0;
      s_alu     <= '0;
      s_wd      <= '0;
      s_wr      <= '0;
      stall_cnt <= '0;
    end else begin
      state <= state_n;
      if (main_from_in) begin
        m_ctrl <= bus.in_ctrl;
        m_alu  <= bus.in_alu_result;
        m_wd   <= bus.in_write_data;
        m_wr   <= bus.in_write_reg;
      end else if (main_from_skid) begin
        m_ctrl <= s_ctrl;
        m_alu  <= s_alu;
        m_wd   <= s_wd;
        m_wr   <= s_wr;
      end
      if (skid_from_in) begin
        s_ctrl <= bus.in_ctrl;
        s_alu  <= bus.in_alu_result;
        s_wd   <= bus.in_write_data;
        s_wr   <= bus.in_write_reg;
      end
      // counts held cycles regardless of flush; saturates instead of wrapping
      if (bus.out_valid & !bus.out_ready & ~&stall_cnt)
        stall_cnt <= stall_cnt + 1'b1;
    end
  end
endmodule

// File: doc/ex_mem_pipe_reg.md
EX_MEM_PIPE_REG -- requirements
Module: ex_mem_pipe_reg

Interface
REQ-001 SHALL have parameter DATA_W, default 32, width of the ALU result and store-data fields.
REQ-002 SHALL have parameter ADDR_W, default 5, width of the destination register index.
REQ-003 SHALL have parameter CTRL_W, default 4, control bundle width; default bit map {MemToReg, RegWrite, MemRead, MemWrite} = bits 3..0.
REQ-004 SHALL have parameter RW_BIT, default 2, index of RegWrite within the control bundle.
REQ-005 SHALL have parameter CNT_W, default 16, width of the stall counter.
REQ-006 SHALL use one clock and an asynchronous, active-high reset, as listed below.
REQ-007 clk  in  1  single clock; all state updates on its rising edge.
REQ-008 rst  in  1  asynchronous, active-high reset.
REQ-009 flush  in  1  discard all held entries (branch/exception squash).
REQ-010 in_valid  in  1  upstream EX stage presents an instruction.
REQ-011 in_ready  out  1  stage accepts the input this cycle.
REQ-012 in_ctrl  in  CTRL_W  control bundle; in_alu_result  in  DATA_W; in_write_data  in  DATA_W; in_write_reg  in  ADDR_W.
REQ-013 out_valid  out  1  output entry valid; out_ready  in  1  MEM stage consumes it.
REQ-014 out_ctrl  out  CTRL_W; out_alu_result  out  DATA_W; out_write_data  out  DATA_W; out_write_reg  out  ADDR_W.
REQ-015 fwd_valid  out  1  forwarding tap: out_valid & out_ctrl[RW_BIT] & (out_write_reg != 0).
REQ-016 stall_cnt  out  CNT_W  count of back-pressure cycles.

Function
REQ-017 SHALL be a two-entry skid buffer (main + skid), states EMPTY, FULL, SKID held in a registered state variable.
REQ-018 Outputs SHALL always come from the main entry; out_valid = (state != EMPTY); in_ready = (state != SKID), decoded from flops only (no combinational path from out_ready).
REQ-019 A transfer in occurs when in_valid & in_ready; a transfer out when out_valid & out_ready.
REQ-020 EMPTY: in_valid -> load main, go FULL; else stay.
REQ-021 FULL: out_ready & in_valid -> main<=input, stay FULL; out_ready & !in_valid -> EMPTY; !out_ready & in_valid -> skid<=input, go SKID; neither -> hold.
REQ-022 SKID: out_ready -> main<=skid, go FULL; else hold; in_valid ignored (in_ready=0).
REQ-023 Latency SHALL be exactly 1 cycle input-to-output when not back-pressured; full throughput of one transfer per cycle.
REQ-024 out_ctrl SHALL be all-zero whenever out_valid=0 (bubble); data fields SHALL hold their last value when not loaded.
REQ-025 flush SHALL take priority over all transfers: next state EMPTY, both entries invalid, out_ctrl zeroed, input that cycle dropped, data fields unchanged.
REQ-026 stall_cnt SHALL increment each cycle out_valid & !out_ready, saturate at all-ones, and be unaffected by flush.
REQ-027 No entry SHALL be lost or duplicated; order SHALL be preserved across SKID.

Reset
REQ-028 On rst assertion, immediately (asynchronously): state EMPTY, out_valid=0, in_ready=1, out_ctrl=0, out_alu_result=0, out_write_data=0, out_write_reg=0, skid contents 0, stall_cnt=0, fwd_valid=0.
REQ-029 Reset asserted mid-transfer SHALL discard both entries; first accept allowed on the first rising edge after deassertion.

Verification
REQ-030 Stream: out_ready=1, in_valid=1 for 4 cycles with alu_result 1,2,3,4 -> outputs 1,2,3,4 one cycle later each, in_ready stays 1, stall_cnt=0.
REQ-031 Back-pressure: load A=0x10, B=0x20 with out_ready=0 -> state SKID, in_ready=0, out=A; raise out_ready -> A then B delivered in order; stall_cnt=2 after 2 held cycles.
REQ-032 Flush in SKID with in_valid=1 -> next cycle out_valid=0, out_ctrl=0, in_ready=1; dropped input never appears.
REQ-033 Forward tap: ctrl=4'b0100, write_reg=5 -> fwd_valid=1; write_reg=0 -> fwd_valid=0; ctrl=4'b0000 -> fwd_valid=0.
REQ-034 Async reset: assert rst between clock edges in FULL -> outputs zero before next edge; stall_cnt saturates at 16'hFFFF after 65535+ held cycles (CNT_W=16).
